jump_resolver: RTL and testbench
================================

Name: jump_resolver

Overview:
- IF/ID stage partner of the instruction fetch unit.
- Captures each fetched instruction and its PC, and decodes jump/branch opcodes.
- Resolves branch conditions, then drives the fetch unit's jumpAddress/jumpEnable redirect inputs.
- Squashes wrong-path instructions fetched before the redirect takes effect, and forwards valid instructions to decode/execute.

Parameters:
- FLUSH_SLOTS, 2: number of captured instructions squashed after a redirect is issued (fetch redirect latency).
- CNT_W, 2: width of the flush counter; must hold FLUSH_SLOTS.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- pcIn  in  16  fetch address of instrIn (fetch unit Daddress).
- instrIn  in  16  instruction word returned for pcIn.
- fetchValid  in  1  instrIn/pcIn are meaningful this cycle.
- stall  in  1  downstream hazard; freezes this stage.
- regA  in  16  register-file value of instr[11:8] field of the held instruction.
- regB  in  16  register-file value of instr[7:4] field of the held instruction.
- jumpAddress  out  16  redirect target to fetch (registered).
- jumpEnable  out  1  one-cycle redirect pulse to fetch (registered).
- instrOut  out  16  held instruction.
- pcOut  out  16  PC of held instruction.
- validOut  out  1  held instruction is on the correct path.

Behaviour:
- Reset (async, immediate): instrOut=0, pcOut=0, validOut=0, jumpAddress=0, jumpEnable=0, flush counter=0, state=RUN.
- Capture: at a posedge with stall=0 and fetchValid=1, load instrOut<=instrIn and pcOut<=pcIn.
  - validOut<=1 in RUN; validOut<=0 in FLUSH.
- Bubble: at a posedge with stall=0 and fetchValid=0, validOut<=0; instrOut/pcOut hold.
- stall=1: instrOut, pcOut, validOut, state and counter all hold; no new redirect is issued.
- Decode: combinational on the held instruction, opcode=instrOut[15:12].
  - 4'hA JMP: taken; target=pcOut+sext(instrOut[11:0]).
  - 4'hB BEQ: taken if regA==regB; target=pcOut+sext(instrOut[3:0]).
  - 4'hC BNE: taken if regA!=regB; target as BEQ.
  - 4'hD JR: taken; target=regA.
  - All other opcodes: not taken.
  - Adds are 16-bit modulo; wrap-around is permitted (16'hFFFF+1=16'h0000).
- Redirect: in RUN with validOut=1, stall=0 and taken, at the next posedge:
  - jumpAddress<=target, jumpEnable<=1, counter<=FLUSH_SLOTS, state<=FLUSH.
  - The branch instruction itself is not squashed; it leaves normally.
- jumpEnable is high for exactly one cycle, even if stall rises in that cycle. jumpAddress holds its last value afterwards.
- FLUSH state:
  - Each capture decrements the counter; the captured slot has validOut=0 and its opcode is ignored.
  - When the counter reaches 0, the next state is RUN, and the following capture is valid.
  - Bubbles and stalls do not decrement the counter.
- Taken branch sitting in IF/ID while stalled: resolves on the first non-stalled cycle, with regA/regB sampled in that cycle.
- Back-to-back taken branches: the second one is always squashed by the first one's FLUSH, so no double redirect is possible.
- Reset mid-FLUSH or mid-pulse: jumpEnable drops immediately and state returns to RUN.
- Latency: capture to instrOut is 1 cycle; taken-branch capture to jumpEnable is 1 cycle.

Test Plan:
- Reset then sequential fetch of pc 0..3 with opcode 4'h1 -> validOut=1 each cycle after capture; jumpEnable stays 0; pcOut follows 0,1,2,3 with 1-cycle lag.
- JMP at pcIn=16'h0010, instr=16'hA005 -> one cycle later jumpEnable=1 for one cycle, jumpAddress=16'h0015. The next 2 captures have validOut=0; the capture after them has validOut=1.
- BEQ instr=16'hB12F at pc 16'h0020 with regA=regB=7 -> jumpAddress=16'h001F (offset -1). Repeat with regA=7, regB=8 -> no jumpEnable, no flush.
- JR instr=16'hD300 with regA=16'h1234 -> jumpAddress=16'h1234. A JMP fetched in the next slot is squashed, giving exactly one jumpEnable pulse.
- Taken JMP held while stall=1 for 3 cycles -> no jumpEnable during stall; pulse on the cycle after stall drops. In FLUSH, a bubble (fetchValid=0) does not shorten the flush.
- Assert reset during FLUSH with counter=1 -> all outputs 0 immediately. After release, the first capture is valid.

Source files
------------

// File: rtl/jump_resolver.sv
// jump_resolver: IF/ID pipeline register paired with the fetch unit.
// Holds the fetched instruction/PC, resolves jumps and branches on the held
// instruction, issues a one-cycle redirect to fetch and squashes the
// wrong-path instructions that were already fetched before it took effect.
module jump_resolver #(
    parameter int FLUSH_SLOTS = 2,
    parameter int CNT_W       = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pcIn,
    input  logic [15:0] instrIn,
    input  logic        fetchValid,
    input  logic        stall,
    input  logic [15:0] regA,
    input  logic [15:0] regB,
    output logic [15:0] jumpAddress,
    output logic        jumpEnable,
    output logic [15:0] instrOut,
    output logic        validOut,
    output logic [15:0] pcOut
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] SLOTS    = CNT_W'(FLUSH_SLOTS);
    localparam logic [CNT_W-1:0] SLOTS_M1 = CNT_W'(FLUSH_SLOTS - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    logic [3:0]  opcode;
    logic        taken;
    logic [15:0] target;
    logic        capture;
    logic        redirect;
    logic        squash;

    assign opcode   = instrOut[15:12];
    assign capture  = !stall && fetchValid;
    assign redirect = (state_reg == RUN) && validOut && !stall && taken;

    // Decode the held instruction into a taken flag and a redirect target.
    always_comb begin
        taken  = 1'b0;
        target = pcOut;
        case (opcode)
            4'hA: begin
                taken  = 1'b1;
                target = pcOut + {{4{instrOut[11]}}, instrOut[11:0]};
            end
            4'hB: begin
                taken  = (regA == regB);
                target = pcOut + {{12{instrOut[3]}}, instrOut[3:0]};
            end
            4'hC: begin
                taken  = (regA != regB);
                target = pcOut + {{12{instrOut[3]}}, instrOut[3:0]};
            end
            4'hD: begin
                taken  = 1'b1;
                target = regA;
            end
            default: begin
                taken  = 1'b0;
                target = pcOut;
            end
        endcase
    end

    // Next-state logic: the slot captured on the redirect edge is already
    // wrong-path, so it is squashed and counted as the first flush slot.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        squash     = 1'b0;
        if (redirect) begin
            squash   = 1'b1;
            cnt_next = capture ? SLOTS_M1 : SLOTS;
            state_next = (cnt_next == '0) ? RUN : FLUSH;
        end else if (state_reg == FLUSH && capture) begin
            squash   = 1'b1;
            cnt_next = cnt_reg - 1'b1;
            if (cnt_next == '0) begin
                state_next = RUN;
            end
        end
    end

    // Pipeline register, redirect outputs and flush bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= RUN;
            cnt_reg     <= '0;
            jumpEnable  <= 1'b0;
            jumpAddress <= '0;
            instrOut    <= '0;
            pcOut       <= '0;
            validOut    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            jumpEnable <= redirect;
            if (redirect) begin
                jumpAddress <= target;
            end
            if (capture) begin
                instrOut <= instrIn;
                pcOut    <= pcIn;
                validOut <= !squash;
            end else if (!stall) begin
                validOut <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jump_resolver.sv
// tb_jump_resolver: directed vector table, reset corner sequence and a
// randomized run checked against a transaction-level reference model.
module tb_jump_resolver;

    localparam int FLUSH_SLOTS = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pcIn = '0;
    logic [15:0] instrIn = '0;
    logic        fetchValid = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] regA = '0;
    logic [15:0] regB = '0;
    logic [15:0] jumpAddress;
    logic        jumpEnable;
    logic [15:0] instrOut;
    logic [15:0] pcOut;
    logic        validOut;

    int checks = 0;
    int errors = 0;

    jump_resolver #(.FLUSH_SLOTS(FLUSH_SLOTS), .CNT_W(2)) dut (
        .clock(clock), .reset(reset), .pcIn(pcIn), .instrIn(instrIn),
        .fetchValid(fetchValid), .stall(stall), .regA(regA), .regB(regB),
        .jumpAddress(jumpAddress), .jumpEnable(jumpEnable),
        .instrOut(instrOut), .pcOut(pcOut), .validOut(validOut)
    );

    always #5 clock = ~clock;

    // Reference model: held slot plus the number of captures still to squash.
    int          m_left  = 0;
    logic [15:0] m_instr = '0;
    logic [15:0] m_pc    = '0;
    logic [15:0] m_jaddr = '0;
    bit          m_valid = 0;
    bit          m_jen   = 0;

    function automatic void resolve(input logic [15:0] ins, input logic [15:0] pc,
                                    input logic [15:0] a, input logic [15:0] b,
                                    output bit tk, output logic [15:0] tg);
        int op;
        int off;
        op  = int'(ins) / 4096;
        tk  = 0;
        tg  = pc;
        if (op == 10) begin
            off = int'(ins) % 4096;
            if (off >= 2048) off -= 4096;
            tk = 1;
            tg = 16'((int'(pc) + off + 65536) % 65536);
        end else if (op == 11 || op == 12) begin
            off = int'(ins) % 16;
            if (off >= 8) off -= 16;
            tk = (op == 11) ? (a == b) : (a != b);
            tg = 16'((int'(pc) + off + 65536) % 65536);
        end else if (op == 13) begin
            tk = 1;
            tg = a;
        end
    endfunction

    task automatic model_reset();
        m_left = 0; m_instr = '0; m_pc = '0; m_jaddr = '0; m_valid = 0; m_jen = 0;
    endtask

    // Drive one cycle of inputs, advance the model, return #1 after the edge.
    task automatic step(input bit fv, input bit st, input logic [15:0] pc,
                        input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b);
        bit          tk;
        bit          redir;
        bit          sq;
        logic [15:0] tg;
        @(negedge clock);
        fetchValid = fv; stall = st; pcIn = pc; instrIn = ins; regA = a; regB = b;
        resolve(m_instr, m_pc, a, b, tk, tg);
        @(posedge clock);
        if (!st) begin
            redir = (m_left == 0) && m_valid && tk;
            m_jen = redir;
            if (redir) m_jaddr = tg;
            if (fv) begin
                sq = (m_left > 0) || redir;
                if (redir) m_left = FLUSH_SLOTS - 1;
                else if (m_left > 0) m_left--;
                m_instr = ins;
                m_pc    = pc;
                m_valid = !sq;
            end else begin
                m_valid = 0;
                if (redir) m_left = FLUSH_SLOTS;
            end
        end else begin
            m_jen = 0;
        end
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          fv;
        bit          st;
        logic [15:0] pc;
        logic [15:0] ins;
        logic [15:0] a;
        logic [15:0] b;
        bit          ejen;
        logic [15:0] ejaddr;
        bit          evalid;
        logic [15:0] epc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit fv, input bit st, input logic [15:0] pc, input logic [15:0] ins,
                       input logic [15:0] a, input logic [15:0] b, input bit ejen,
                       input logic [15:0] ejaddr, input bit evalid, input logic [15:0] epc);
        vec_t v;
        v = '{fv, st, pc, ins, a, b, ejen, ejaddr, evalid, epc};
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // sequential fetch
        add(1,0,16'h0000,16'h1000,0,0, 0,16'h0000,1,16'h0000);
        add(1,0,16'h0001,16'h1000,0,0, 0,16'h0000,1,16'h0001);
        add(1,0,16'h0002,16'h1000,0,0, 0,16'h0000,1,16'h0002);
        add(1,0,16'h0003,16'h1000,0,0, 0,16'h0000,1,16'h0003);
        // JMP +5
        add(1,0,16'h0010,16'hA005,0,0, 0,16'h0000,1,16'h0010);
        add(1,0,16'h0011,16'h1000,0,0, 1,16'h0015,0,16'h0011);
        add(1,0,16'h0015,16'h1000,0,0, 0,16'h0015,0,16'h0015);
        add(1,0,16'h0016,16'h1000,0,0, 0,16'h0015,1,16'h0016);
        // BEQ taken, offset -1
        add(1,0,16'h0020,16'hB12F,7,7, 0,16'h0015,1,16'h0020);
        add(1,0,16'h0021,16'h1000,7,7, 1,16'h001F,0,16'h0021);
        add(1,0,16'h001F,16'h1000,7,7, 0,16'h001F,0,16'h001F);
        add(1,0,16'h0030,16'h1000,7,7, 0,16'h001F,1,16'h0030);
        // BEQ not taken
        add(1,0,16'h0040,16'hB12F,7,8, 0,16'h001F,1,16'h0040);
        add(1,0,16'h0041,16'h1000,7,8, 0,16'h001F,1,16'h0041);
        add(1,0,16'h0042,16'h1000,7,8, 0,16'h001F,1,16'h0042);
        // JR followed by a JMP that must be squashed
        add(1,0,16'h0050,16'hD300,16'h1234,0, 0,16'h001F,1,16'h0050);
        add(1,0,16'h0051,16'hA005,16'h1234,0, 1,16'h1234,0,16'h0051);
        add(1,0,16'h1234,16'h1000,16'h1234,0, 0,16'h1234,0,16'h1234);
        add(1,0,16'h1235,16'h1000,16'h1234,0, 0,16'h1234,1,16'h1235);
        // JMP held under a 3-cycle stall, then a bubble inside the flush
        add(1,0,16'h0060,16'hA005,0,0, 0,16'h1234,1,16'h0060);
        add(1,1,16'h0061,16'h1000,0,0, 0,16'h1234,1,16'h0060);
        add(1,1,16'h0061,16'h1000,0,0, 0,16'h1234,1,16'h0060);
        add(1,1,16'h0061,16'h1000,0,0, 0,16'h1234,1,16'h0060);
        add(1,0,16'h0061,16'h1000,0,0, 1,16'h0065,0,16'h0061);
        add(0,0,16'h0062,16'h1000,0,0, 0,16'h0065,0,16'h0061);
        add(1,0,16'h0065,16'h1000,0,0, 0,16'h0065,0,16'h0065);
        add(1,0,16'h0066,16'h1000,0,0, 0,16'h0065,1,16'h0066);
        // stall rising during the redirect pulse
        add(1,0,16'h0070,16'hA005,0,0, 0,16'h0065,1,16'h0070);
        add(1,0,16'h0071,16'h1000,0,0, 1,16'h0075,0,16'h0071);
        add(1,1,16'h0075,16'h1000,0,0, 0,16'h0075,0,16'h0071);
        add(1,0,16'h0075,16'h1000,0,0, 0,16'h0075,0,16'h0075);
        add(1,0,16'h0076,16'h1000,0,0, 0,16'h0075,1,16'h0076);
        // target wrap-around FFFF+1
        add(1,0,16'hFFFF,16'hA001,0,0, 0,16'h0075,1,16'hFFFF);
        add(1,0,16'h0000,16'h1000,0,0, 1,16'h0000,0,16'h0000);
        add(1,0,16'h0000,16'h1000,0,0, 0,16'h0000,0,16'h0000);
        add(1,0,16'h0001,16'h1000,0,0, 0,16'h0000,1,16'h0001);
        // BNE taken, offset +2
        add(1,0,16'h0100,16'hC002,1,2, 0,16'h0000,1,16'h0100);
        add(1,0,16'h0101,16'h1000,1,2, 1,16'h0102,0,16'h0101);
        add(1,0,16'h0102,16'h1000,1,2, 0,16'h0102,0,16'h0102);
        add(1,0,16'h0103,16'h1000,1,2, 0,16'h0102,1,16'h0103);

        // reset state
        #12;
        chk("reset_jen", 16'(jumpEnable), 16'h0);
        chk("reset_jaddr", jumpAddress, 16'h0);
        chk("reset_valid", 16'(validOut), 16'h0);
        chk("reset_pc", pcOut, 16'h0);
        chk("reset_instr", instrOut, 16'h0);
        reset = 1'b0;
        model_reset();

        foreach (vecs[i]) begin
            step(vecs[i].fv, vecs[i].st, vecs[i].pc, vecs[i].ins, vecs[i].a, vecs[i].b);
            $display("vec %0d: pc=%h instr=%h jen=%0b jaddr=%h valid=%0b pcOut=%h",
                     i, vecs[i].pc, vecs[i].ins, jumpEnable, jumpAddress, validOut, pcOut);
            chk($sformatf("vec%0d_jen", i), 16'(jumpEnable), 16'(vecs[i].ejen));
            chk($sformatf("vec%0d_jaddr", i), jumpAddress, vecs[i].ejaddr);
            chk($sformatf("vec%0d_valid", i), 16'(validOut), 16'(vecs[i].evalid));
            chk($sformatf("vec%0d_pc", i), pcOut, vecs[i].epc);
        end

        // reset asserted mid-pulse with one flush slot left
        step(1,0,16'h0080,16'hA005,0,0);
        step(1,0,16'h0081,16'h1000,0,0);
        chk("midflush_jen_before", 16'(jumpEnable), 16'h1);
        #2 reset = 1'b1;
        #1;
        $display("reset mid-flush: jen=%0b valid=%0b pcOut=%h", jumpEnable, validOut, pcOut);
        chk("midflush_jen", 16'(jumpEnable), 16'h0);
        chk("midflush_jaddr", jumpAddress, 16'h0);
        chk("midflush_valid", 16'(validOut), 16'h0);
        chk("midflush_pc", pcOut, 16'h0);
        chk("midflush_instr", instrOut, 16'h0);
        fetchValid = 1'b0;
        reset = 1'b0;
        model_reset();
        step(1,0,16'h0090,16'h1000,0,0);
        chk("after_reset_valid", 16'(validOut), 16'h1);
        chk("after_reset_pc", pcOut, 16'h0090);
        step(1,0,16'h0091,16'hA005,0,0);
        step(1,0,16'h0092,16'h1000,0,0);
        chk("after_reset_jen", 16'(jumpEnable), 16'h1);
        chk("after_reset_jaddr", jumpAddress, 16'h0096);

        // randomized run against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [3:0]  op;
            logic [15:0] ins;
            int          sel;
            bit          fv;
            bit          st;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: op = 4'hA;
                1: op = 4'hB;
                2: op = 4'hC;
                3: op = 4'hD;
                default: op = 4'($urandom_range(0, 15));
            endcase
            ins = {op, 12'($urandom)};
            fv  = ($urandom_range(0, 9) < 8);
            st  = ($urandom_range(0, 9) < 2);
            step(fv, st, 16'($urandom), ins, 16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)));
            $display("rnd %0d: fv=%0b st=%0b jen=%0b jaddr=%h valid=%0b pcOut=%h",
                     n, fv, st, jumpEnable, jumpAddress, validOut, pcOut);
            chk($sformatf("rnd%0d_jen", n), 16'(jumpEnable), 16'(m_jen));
            chk($sformatf("rnd%0d_jaddr", n), jumpAddress, m_jaddr);
            chk($sformatf("rnd%0d_valid", n), 16'(validOut), 16'(m_valid));
            chk($sformatf("rnd%0d_pc", n), pcOut, m_pc);
            chk($sformatf("rnd%0d_instr", n), instrOut, m_instr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
